sdpram_stream_reader: RTL
=========================

Name: sdpram_stream_reader

Overview:
- Read-side master for the simple dual-port RAM. It streams a block of consecutive words out of the RAM read port onto a valid/ready stream.
- Used for framebuffer scanout and tile readback.
- Absorbs the RAM's 1-cycle registered read latency with an internal 2-entry skid buffer, so it sustains 1 word/cycle under no backpressure and loses no data under backpressure.

Parameters:
- DATA_W, 32, RAM word width; also the stream data width.
- DEPTH, 16, RAM depth in words. ADDR_W = $clog2(DEPTH) is derived.
- LEN_W, ADDR_W+1, width of the transfer length, so a length of DEPTH is expressible.

Ports:
- clk  input  1  single clock for all logic; drives the RAM read clock.
- rstN  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a transfer; ignored while busy=1.
- baseAddr  input  ADDR_W  first word address; sampled when start is accepted.
- len  input  LEN_W  number of words to transfer; sampled when start is accepted.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the last word has been accepted downstream.
- rdEn  output  1  RAM read enable.
- rdAddr  output  ADDR_W  RAM read address.
- rdData  input  DATA_W  RAM read data, valid on the cycle after rdEn.
- outValid  output  1  stream word available.
- outReady  input  1  downstream accepts the word.
- outData  output  DATA_W  stream word.
- outLast  output  1  qualifies the final word of the transfer.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; busy, done, rdEn, outValid, outLast = 0; rdAddr, outData = 0; buffer empty; counters 0.
- States and transitions:
  - IDLE: start=1 with len=0 -> no reads, done=1 next cycle, stay IDLE.
  - IDLE: start=1 with len>0 -> latch baseAddr/len, go to ISSUE.
  - ISSUE: on the cycle issued==len, go to DRAIN.
  - DRAIN: when the final word handshakes (outValid & outReady & outLast), pulse done and go to IDLE.
- Issue rule: in ISSUE, assert rdEn when (bufCount + inFlight) < 2. Each issue increments rdAddr modulo DEPTH, so DEPTH-1 wraps to 0. inFlight is 1 for the cycle after rdEn.
- Capture: the cycle after rdEn, rdData is written into the skid buffer.
- Buffer ordering: the buffer is a 2-entry FIFO. outData/outValid come from its head; words are never reordered.
- Simultaneous push and pop: bufCount is unchanged and data order is preserved.
- outLast: asserted with the head word when that word is word index len-1.
- Throughput: first outValid appears 2 cycles after start is accepted (1 cycle to ISSUE, 1 cycle of RAM latency). With outReady held high, one word per cycle follows.
- Backpressure: with outReady=0, outValid/outData/outLast hold stable. At most 2 words are buffered. rdEn stays low once occupancy plus in-flight reaches 2.
- start while busy: ignored, no effect on the running transfer.
- Reset mid-transfer: the transfer is abandoned, the buffer is flushed, and no done pulse is produced.
- Transfers longer than DEPTH are not supported: len is saturated to DEPTH.

Optional Feature:
- Macro: SDPRAM_STREAM_LOOP_EN.
- Defined: adds input loop.
  - If loop=1 when the last word is accepted, the transfer restarts at the latched baseAddr with the same len, with no idle cycle; outLast still marks each pass.
  - done pulses only on the pass during which loop is 0.
- Undefined: single-pass only; no loop port.

Decomposition:
- Shared package holds:
  - State enum: IDLE, ISSUE, DRAIN.
  - Default DATA_W/DEPTH constants shared with the RAM block.
  - Skid-depth constant = 2.
- Natural sub-module: sdpram_skid_fifo. It is a 2-entry synchronous FIFO with push, pop, count, head data, and async active-low reset.
- The top level holds the FSM, address and length counters, and the issue/in-flight logic.

Test Plan:
- RAM preloaded with mem[i]=i; base=3, len=4, outReady=1 -> data 3,4,5,6 on consecutive cycles, first outValid 2 cycles after start, outLast on 6, done the cycle after that handshake.
- base=14, len=4, DEPTH=16 -> rdAddr sequence 14,15,0,1; data 14,15,0,1.
- outReady toggling 1,0,0,1,0,1 over base=0, len=8 -> all 8 words in order, none duplicated or lost; outData stable while stalled; rdEn never asserted when occupancy plus in-flight is 2.
- len=0 -> zero rdEn pulses, done exactly 1 cycle later, busy stays 0.
- start re-pulsed mid-transfer, then rstN dropped after 2 words -> the second start has no effect; after reset all outputs are 0 and no done pulse occurs. A fresh start then completes normally.
- With SDPRAM_STREAM_LOOP_EN defined, loop=1 for 2 passes, base=5, len=2 -> stream 5,6,5,6,5,6 with outLast on each 6 and a single done at the end.

Source files
------------

// File: rtl/sdpram_stream_reader_pkg.sv
// Shared constants and FSM encoding for the SDP RAM stream reader and the RAM block it reads.
package sdpram_stream_reader_pkg;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 16;
    localparam int SKID_DEPTH     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/sdpram_skid_fifo.sv
// Two-entry synchronous FIFO that parks RAM read data while the stream is stalled.
module sdpram_skid_fifo
    import sdpram_stream_reader_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
)(
    input  logic              clk,
    input  logic              rstN,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] headData
);
    logic [DATA_W-1:0] mem [SKID_DEPTH];
    logic              wrPtr;
    logic              rdPtr;
    logic              doPush;
    logic              doPop;

    assign doPop    = pop && (count != 2'd0);
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign doPush   = push && ((count != 2'd2) || doPop);
    assign headData = mem[rdPtr];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= ~wrPtr;
            end
            if (doPop) rdPtr <= ~rdPtr;
            case ({doPush, doPop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sdpram_stream_reader.sv
// Streams len consecutive RAM words from baseAddr onto a valid/ready stream.
// Optional SDPRAM_STREAM_LOOP_EN adds a loop input that replays the block back to back.
module sdpram_stream_reader
    import sdpram_stream_reader_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH),
    parameter  int LEN_W  = ADDR_W + 1
)(
    input  logic              clk,
    input  logic              rstN,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [LEN_W-1:0]  len,
`ifdef SDPRAM_STREAM_LOOP_EN
    input  logic              loop,
`endif
    output logic              busy,
    output logic              done,
    output logic              rdEn,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] rdData,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outData,
    output logic              outLast
);
    state_e            state;
    state_e            nextState;
    logic [ADDR_W-1:0] baseReg;
    logic [LEN_W-1:0]  lenReg;
    logic [LEN_W-1:0]  lenSat;
    logic [LEN_W-1:0]  lastIdx;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  accepted;
    logic              inFlight;
    logic              loopSel;
    logic              launch;
    logic              handshake;
    logic              finalHs;
    logic              restart;
    logic              doneNext;
    logic [1:0]        bufCount;
    logic [DATA_W-1:0] headData;
    logic              bypass;
    logic              bufPush;
    logic              bufPop;

`ifdef SDPRAM_STREAM_LOOP_EN
    assign loopSel = loop;
`else
    assign loopSel = 1'b0;
`endif

    assign lenSat    = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
    assign launch    = (state == IDLE) && start && (lenSat != '0);
    assign lastIdx   = lenReg - LEN_W'(1);

    // The word returning from the RAM is offered directly when nothing older is parked,
    // which is what keeps one word per cycle flowing with no backpressure.
    assign outValid  = (bufCount != 2'd0) || inFlight;
    assign outData   = (bufCount != 2'd0) ? headData : (inFlight ? rdData : '0);
    assign outLast   = outValid && (accepted == lastIdx);
    assign handshake = outValid && outReady;
    assign finalHs   = handshake && outLast;
    assign restart   = finalHs && loopSel;

    assign bypass    = inFlight && (bufCount == 2'd0) && outReady;
    assign bufPush   = inFlight && !bypass;
    assign bufPop    = outReady && (bufCount != 2'd0);

    sdpram_skid_fifo #(.DATA_W(DATA_W)) skid (
        .clk      (clk),
        .rstN     (rstN),
        .push     (bufPush),
        .pushData (rdData),
        .pop      (bufPop),
        .count    (bufCount),
        .headData (headData)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (start && (lenSat != '0)) nextState = ISSUE;
            // With len=1 the only word can hand off while still in ISSUE.
            ISSUE: if (finalHs)              nextState = loopSel ? ISSUE : IDLE;
                   else if (issued == lenReg) nextState = DRAIN;
            DRAIN: if (finalHs)              nextState = loopSel ? ISSUE : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        rdEn     = (state == ISSUE) && (issued != lenReg) &&
                   (({1'b0, bufCount} + {2'b00, inFlight}) < 3'd2);
        doneNext = ((state == IDLE) && start && (lenSat == '0)) ||
                   ((state != IDLE) && finalHs && !loopSel);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            baseReg  <= '0;
            lenReg   <= '0;
            issued   <= '0;
            accepted <= '0;
            rdAddr   <= '0;
            inFlight <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= doneNext;
            inFlight <= rdEn;
            if (launch) begin
                baseReg  <= baseAddr;
                lenReg   <= lenSat;
                rdAddr   <= baseAddr;
                issued   <= '0;
                accepted <= '0;
            end else if (restart) begin
                rdAddr   <= baseReg;
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (rdEn) begin
                    rdAddr <= (rdAddr == ADDR_W'(DEPTH - 1)) ? '0 : rdAddr + ADDR_W'(1);
                    issued <= issued + LEN_W'(1);
                end
                if (handshake) accepted <= accepted + LEN_W'(1);
            end
        end
    end
endmodule
